// File: rtl/direction_encoder_pkg.sv
// -----------------------------------------------------------------------------
// direction_encoder_pkg
//
// Shared definitions for the direction encoder and the game-logic block that
// consumes its output.
//   - act_t        : 3-bit committed action code
//   - ACT_*        : action code constants (idle/up/down/left/right)
//   - opposite_dir : returns the direction opposite to a given code
//   - encode_press : fixed-priority encoder of simultaneous press pulses
// -----------------------------------------------------------------------------
package direction_encoder_pkg;

  localparam int ACT_W = 3;

  typedef logic [ACT_W-1:0] act_t;

  localparam act_t ACT_IDLE  = 3'd0;
  localparam act_t ACT_UP    = 3'd1;
  localparam act_t ACT_DOWN  = 3'd2;
  localparam act_t ACT_LEFT  = 3'd3;
  localparam act_t ACT_RIGHT = 3'd4;

  // Button vector index order used everywhere a 4-bit press/level vector
  // appears: bit 0 top, bit 1 bottom, bit 2 left, bit 3 right.
  localparam int BTN_TOP    = 0;
  localparam int BTN_BOTTOM = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;

  // Opposite direction; idle (and any unused code) maps to idle so that an
  // idle pending value never blocks a request.
  function automatic act_t opposite_dir(input act_t a);
    act_t r;
    case (a)
      ACT_UP:    r = ACT_DOWN;
      ACT_DOWN:  r = ACT_UP;
      ACT_LEFT:  r = ACT_RIGHT;
      ACT_RIGHT: r = ACT_LEFT;
      default:   r = ACT_IDLE;
    endcase
    return r;
  endfunction

  // Top > Bottom > Left > Right when several pulses land in the same cycle.
  function automatic act_t encode_press(input logic [3:0] press);
    act_t r;
    if (press[BTN_TOP])         r = ACT_UP;
    else if (press[BTN_BOTTOM]) r = ACT_DOWN;
    else if (press[BTN_LEFT])   r = ACT_LEFT;
    else if (press[BTN_RIGHT])  r = ACT_RIGHT;
    else                        r = ACT_IDLE;
    return r;
  endfunction

endpackage

// File: rtl/direction_encoder_if.sv
// -----------------------------------------------------------------------------
// direction_encoder_if
//
// Bundles the button inputs and the action/step outputs of direction_encoder.
//   BtnTop/BtnBottom/BtnLeft/BtnRight : raw asynchronous push buttons (high =
//                                       pressed), driven by the master side
//   accion                            : committed action code (act_t)
//   mover                             : one-cycle step strobe
//   pending                           : debug view of the pending request
//   btn_level                         : debug view of the debounced levels
//                                       (bit 0 top, 1 bottom, 2 left, 3 right)
//
// Handshake: there is no back-pressure. mover is a single-cycle strobe; a
// consumer samples accion on the clock edge where it sees mover high. accion
// is loaded one cycle before mover rises and then holds for the rest of the
// period, so it is always stable around the strobe.
// -----------------------------------------------------------------------------
interface direction_encoder_if;
  import direction_encoder_pkg::*;

  logic       BtnTop;
  logic       BtnBottom;
  logic       BtnLeft;
  logic       BtnRight;
  act_t       accion;
  logic       mover;
  act_t       pending;
  logic [3:0] btn_level;

  modport master (
    output BtnTop, BtnBottom, BtnLeft, BtnRight,
    input  accion, mover, pending, btn_level
  );

  modport slave (
    input  BtnTop, BtnBottom, BtnLeft, BtnRight,
    output accion, mover, pending, btn_level
  );

endinterface

// File: rtl/direction_encoder_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// One push-button conditioning channel: 2-flop synchronizer, debounce counter
// and press-pulse generator.
//   Parameters: DEBOUNCE_CYCLES - consecutive cycles the synchronized level
//                                 must differ before the debounced level flips
//   Ports: uclk    - system clock
//          reset   - asynchronous active-high reset
//          btn_raw - raw asynchronous button
//          level   - debounced level
//          press   - one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic uclk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          btn_sync;

  assign btn_sync = sync_q[1];

  // The counter measures how long the synchronized level has disagreed with
  // the debounced level; any agreement restarts the count, so only a run of
  // DEBOUNCE_CYCLES consecutive disagreeing cycles flips the level. The press
  // pulse is raised on the same edge as the 0->1 flip; releases are silent.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      press  <= 1'b0;
      if (btn_sync != level) begin
        if (cnt_q == CNT_MAX) begin
          level <= btn_sync;
          cnt_q <= '0;
          press <= btn_sync;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/direction_encoder.sv
// -----------------------------------------------------------------------------
// direction_encoder
//
// Turns four push buttons into a periodic movement command for a game.
// Each button is synchronized and debounced; a debounced press becomes a
// request code that overwrites the pending register. A free-running tick
// counter commits pending to accion once per MOVE_PERIOD cycles and issues a
// one-cycle mover strobe on the following cycle.
//
//   Parameters: DEBOUNCE_CYCLES - button stability time in uclk cycles
//               MOVE_PERIOD     - cycles between mover strobes (>= 4)
//   Ports: uclk  - system clock (rising edge)
//          reset - asynchronous active-high reset
//          bus   - direction_encoder_if.slave: buttons in, accion/mover out,
//                  plus debug views of pending and the debounced levels
//
//   Build option: define REVERSE_BLOCK_EN to reject a request that is the
//   exact opposite of the current pending direction (up<->down,
//   left<->right). Without it every request is accepted.
// -----------------------------------------------------------------------------
module direction_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MOVE_PERIOD     = 5000000
) (
  input  logic                uclk,
  input  logic                reset,
  direction_encoder_if.slave  bus
);
  import direction_encoder_pkg::*;

  localparam int TW = $clog2(MOVE_PERIOD);
  localparam logic [TW-1:0] TICK_MAX = TW'(MOVE_PERIOD - 1);

  logic [3:0]    raw_vec;
  logic [3:0]    level_vec;
  logic [3:0]    press_vec;

  act_t          req;
  logic          req_valid;
  logic          req_accept;

  logic [TW-1:0] tick_q;
  logic          wrap;
  logic          commit_q;
  logic          mover_q;
  act_t          pending_q;
  act_t          accion_q;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  assign raw_vec[BTN_TOP]    = bus.BtnTop;
  assign raw_vec[BTN_BOTTOM] = bus.BtnBottom;
  assign raw_vec[BTN_LEFT]   = bus.BtnLeft;
  assign raw_vec[BTN_RIGHT]  = bus.BtnRight;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .uclk    (uclk),
      .reset   (reset),
      .btn_raw (raw_vec[i]),
      .level   (level_vec[i]),
      .press   (press_vec[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Request encoding and acceptance
  // ---------------------------------------------------------------------------
  assign req       = encode_press(press_vec);
  assign req_valid = (req != ACT_IDLE);

`ifdef REVERSE_BLOCK_EN
  // opposite_dir(ACT_IDLE) is ACT_IDLE, which never equals a valid request,
  // so an idle pending value accepts anything. A request equal to pending is
  // accepted and simply rewrites the same value.
  assign req_accept = req_valid && (req != opposite_dir(pending_q));
`else
  assign req_accept = req_valid;
`endif

  // ---------------------------------------------------------------------------
  // Period timer, commit and strobe
  // ---------------------------------------------------------------------------
  assign wrap = (tick_q == TICK_MAX);

  // On the wrap edge accion takes the pending value held before that edge,
  // so a request landing on the same edge only reaches the next commit.
  // commit_q marks the cycle after the commit; mover is its registered copy,
  // which puts the strobe one edge after accion changes and restarts the
  // whole schedule MOVE_PERIOD cycles after reset release.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      commit_q  <= 1'b0;
      mover_q   <= 1'b0;
      pending_q <= ACT_IDLE;
      accion_q  <= ACT_IDLE;
    end else begin
      tick_q   <= wrap ? '0 : tick_q + 1'b1;
      commit_q <= wrap;
      mover_q  <= commit_q;
      if (wrap) begin
        accion_q <= pending_q;
      end
      if (req_accept) begin
        pending_q <= req;
      end
    end
  end

  assign bus.accion    = accion_q;
  assign bus.mover     = mover_q;
  assign bus.pending   = pending_q;
  assign bus.btn_level = level_vec;

endmodule
